// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES definitions for the iterative encrypt and decrypt
//            cores: forward and inverse S-box tables, column count, the
//            128-bit state type, byte/column extraction helpers, xtime and
//            the encryptor FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int Nb = 4;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_enc_fsm_e;

    // Entry 0x00 occupies the most significant byte of each table.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // {~b, 3'b000} == (255 - b) * 8, the LSB offset of entry b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return c_inv_sbox[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 is bits [127:120]; bytes are numbered column-major.
    function automatic logic [7:0] byte_of(input aes_state_t s, input logic [3:0] idx);
        return s[{~idx, 3'b000} +: 8];
    endfunction

    // Column 0 is bits [127:96].
    function automatic logic [31:0] col_of(input aes_state_t s, input logic [1:0] c);
        return s[{~c, 5'b00000} +: 32];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_round
// Purpose  : Combinational AES encryption round:
//            SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//            final_round bypasses MixColumns for the last round.
// Ports    : state       in  128  current cipher state
//            round_key   in  128  key added at the end of the round
//            final_round in  1    skip MixColumns
//            result      out 128  next cipher state
// Revision : 1.0 - initial release
// ============================================================================
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] result
);

    logic [127:0] w_shifted;
    logic [127:0] w_mixed;

    // Output byte (row r, column c) takes the S-box of input byte
    // (row r, column (c + r) mod 4), merging SubBytes and ShiftRows.
    genvar c, r;
    generate
        for (c = 0; c < Nb; c++) begin : g_col
            for (r = 0; r < 4; r++) begin : g_row
                assign w_shifted[127 - 8*(4*c + r) -: 8] =
                    sbox(byte_of(state, 4'(4*((c + r) % 4) + r)));
            end

            logic [31:0] w_col;
            logic [7:0]  w_a0, w_a1, w_a2, w_a3;
            assign w_col = col_of(w_shifted, 2'(c));
            assign w_a0  = w_col[31:24];
            assign w_a1  = w_col[23:16];
            assign w_a2  = w_col[15:8];
            assign w_a3  = w_col[7:0];

            assign w_mixed[127 - 32*c -: 32] = {
                xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3,
                w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3,
                xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3)
            };
        end
    endgenerate

    assign result = (final_round ? w_shifted : w_mixed) ^ round_key;

endmodule
`default_nettype wire

// File: rtl/aes_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_encrypt_core
// Purpose  : Iterative AES-128/192/256 encryptor, one round per clock, with
//            valid/ready handshakes on input and output. Round keys come
//            pre-expanded on all_keys (round key 0 at the MSBs) and must be
//            held stable while a block is in flight.
// Config   : AES_ENC_ZEROIZE_EN - clear the state on output handoff and
//            present zero on ciphertext whenever out_valid is low.
// Ports    : clk, reset (async, active-high)
//            in_valid / in_ready / plaintext     input handshake + block
//            all_keys                            (Nr+1)*128 key schedule
//            out_valid / out_ready / ciphertext  output handshake + block
//            busy                                block in ROUND or DONE
// Revision : 1.0 - initial release
// ============================================================================
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          plaintext,
    input  logic [(Nr+1)*128-1:0] all_keys,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          ciphertext,
    output logic                  busy
);

    generate
        if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_cfg_check
            $error("aes_encrypt_core: unsupported Nk/Nr combination");
        end
    endgenerate

    localparam logic [3:0] c_last_rnd = 4'(Nr);

    aes_enc_fsm_e r_fsm;
    logic [3:0]   r_rnd;
    aes_state_t   r_state;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [127:0] w_rk [0:Nr];
    logic [3:0]   w_key_idx;
    logic         w_final;
    logic [127:0] w_round_out;

    genvar k;
    generate
        for (k = 0; k <= Nr; k++) begin : g_rk
            assign w_rk[k] = all_keys[(Nr + 1 - k)*128 - 1 -: 128];
        end
    endgenerate

    // Clamp so encodings above Nr never select past the last round key.
    assign w_key_idx = (r_rnd > c_last_rnd) ? c_last_rnd : r_rnd;
    assign w_final   = (r_rnd >= c_last_rnd);

    aes_enc_round u_round (
        .state       (r_state),
        .round_key   (w_rk[w_key_idx]),
        .final_round (w_final),
        .result      (w_round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm       <= ST_IDLE;
            r_rnd       <= 4'd1;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state    <= plaintext ^ w_rk[0];
                        r_rnd      <= 4'd1;
                        r_fsm      <= ST_ROUND;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_state <= w_round_out;
                    if (w_final) begin
                        r_fsm       <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_fsm       <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
`ifdef AES_ENC_ZEROIZE_EN
                        r_state     <= '0;
`endif
                    end
                end
                default: begin
                    r_fsm       <= ST_IDLE;
                    r_rnd       <= 4'd1;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

`ifdef AES_ENC_ZEROIZE_EN
    // Intermediate round values never appear on the output bus.
    assign ciphertext = r_out_valid ? r_state : 128'd0;
`else
    assign ciphertext = r_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_encrypt_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encrypt_core
// Purpose  : Self-checking bench for aes_encrypt_core. Runs AES-128/192/256
//            known-answer vectors, backpressure, back-to-back random blocks
//            and a mid-round reset against an independent reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_encrypt_core;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           iv_a, ir_a, ov_a, or_a, busy_a;
    logic           iv_b, or_b, ir_b, ov_b, busy_b, ir_c, ov_c, busy_c;
    logic [127:0]   pt, ct_a, ct_b, ct_c;
    logic [1407:0]  ak_a;
    logic [1663:0]  ak_b;
    logic [1919:0]  ak_c;

    aes_encrypt_core #(.Nk(4), .Nr(10)) u_dut128 (
        .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .plaintext(pt),
        .all_keys(ak_a), .out_valid(ov_a), .out_ready(or_a), .ciphertext(ct_a), .busy(busy_a));
    aes_encrypt_core #(.Nk(6), .Nr(12)) u_dut192 (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .plaintext(pt),
        .all_keys(ak_b), .out_valid(ov_b), .out_ready(or_b), .ciphertext(ct_b), .busy(busy_b));
    aes_encrypt_core #(.Nk(8), .Nr(14)) u_dut256 (
        .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_c), .plaintext(pt),
        .all_keys(ak_c), .out_valid(ov_c), .out_ready(or_b), .ciphertext(ct_c), .busy(busy_c));

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   sbox_t [256];
    logic [1919:0] ks128, ks192, ks256;

    localparam logic [127:0] c_pt_kat = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    function automatic logic [1919:0] expand_keys(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] bus;
        rc  = 8'h01;
        bus = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nr + 1); i++) bus[1919 - 32*i -: 32] = w[i];
        return bus;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127 - 8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) b[4*c + r] = a[4*((c + r) % 4) + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a[4*c]   = gmul(b[4*c],8'h02) ^ gmul(b[4*c+1],8'h03) ^ b[4*c+2] ^ b[4*c+3];
                a[4*c+1] = b[4*c] ^ gmul(b[4*c+1],8'h02) ^ gmul(b[4*c+2],8'h03) ^ b[4*c+3];
                a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2],8'h02) ^ gmul(b[4*c+3],8'h03);
                a[4*c+3] = gmul(b[4*c],8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3],8'h02);
            end
            for (int i = 0; i < 16; i++) b[i] = a[i];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
        return o;
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] p, input logic [1919:0] ks, input int nr);
        logic [127:0] s;
        s = p ^ ks[1919 -: 128];
        for (int r = 1; r <= nr; r++) s = ref_round(s, r == nr) ^ ks[1919 - 128*r -: 128];
        return s;
    endfunction

    // ---------------- output scoreboard (128-bit core) ----------------
    always @(negedge clk) begin
        if (ov_a === 1'b1 && or_a === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_output: observed %h expected none", ct_a);
            end
            if (exp_q.size() != 0) check("scoreboard", ct_a, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat_a, lat_b, lat_c, gap, waited;
        logic [7:0] inv, s;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[x] = s;
        end
        ks128 = expand_keys({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        ks192 = expand_keys({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
        ks256 = expand_keys(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        ak_a = ks128[1919 -: 1408];
        ak_b = ks192[1919 -: 1664];
        ak_c = ks256;

        reset = 1'b1; iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b0; or_b = 1'b0; pt = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", ir_a, 1);
        check("rst_out_valid", ov_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ciphertext", ct_a, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", ir_a, 1);

        // Known-answer vectors on all three key sizes, accepted on one edge.
        pt = c_pt_kat;
        exp_q.push_back(c_ct128);
        iv_a = 1'b1; iv_b = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0; iv_b = 1'b0;
        check("accept_in_ready", ir_a, 0);
        check("accept_busy", busy_a, 1);
        lat_a = 0; lat_b = 0; lat_c = 0;
        for (int k = 1; k <= 30; k++) begin
            if (ov_a && lat_a == 0) lat_a = k;
            if (ov_b && lat_b == 0) lat_b = k;
            if (ov_c && lat_c == 0) lat_c = k;
            if (lat_a != 0 && lat_b != 0 && lat_c != 0) break;
            @(posedge clk); #1;
        end
        check("latency128", lat_a, 11);
        check("latency192", lat_b, 13);
        check("latency256", lat_c, 15);
        check("kat192", ct_b, c_ct192);
        check("kat256", ct_c, c_ct256);
        check("done_busy", busy_a, 1);

        // Backpressure: output held, a second in_valid is ignored.
        for (int k = 0; k < 20; k++) begin
            pt   = 128'hdeadbeef_00000000_cafef00d_12345678;
            iv_a = (k == 5);
            @(posedge clk); #1;
            check("bp_out_valid", ov_a, 1);
            check("bp_ciphertext", ct_a, c_ct128);
            check("bp_in_ready", ir_a, 0);
        end
        iv_a = 1'b0; or_a = 1'b1; or_b = 1'b1;
        @(posedge clk); #1;
        or_a = 1'b0; or_b = 1'b0;
        check("handoff_out_valid", ov_a, 0);
        check("handoff_in_ready", ir_a, 1);
        check("handoff_busy", busy_a, 0);
        check("handoff_out_valid192", ov_b, 0);
        check("handoff_out_valid256", ov_c, 0);
`ifdef AES_ENC_ZEROIZE_EN
        check("handoff_ciphertext", ct_a, 128'd0);
`else
        check("handoff_ciphertext", ct_a, c_ct128);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("no_ghost_block", ov_a, 0);
        check("queue_drained_kat", exp_q.size(), 0);

        // Back-to-back: in_valid and out_ready held high.
        iv_a = 1'b1; or_a = 1'b1; gap = 0;
        for (int blk = 0; blk < 4; blk++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(ref_enc(pt, ks128, 10));
            waited = 0;
            while (ir_a !== 1'b1 && waited < 40) begin
                @(posedge clk); #1;
                waited++; gap++;
            end
            check("b2b_ready_seen", ir_a, 1);
            @(posedge clk); #1;
            gap++;
            if (blk > 0) check("b2b_spacing", gap, 12);
            gap = 0;
        end
        iv_a = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("queue_drained_b2b", exp_q.size(), 0);
        or_a = 1'b0;

        // Reset during round 5 discards the block.
        pt = {$urandom, $urandom, $urandom, $urandom};
        iv_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midround_busy", busy_a, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("postrst_in_ready", ir_a, 1);
        check("postrst_out_valid", ov_a, 0);
        check("postrst_busy", busy_a, 0);
        check("postrst_ciphertext", ct_a, 0);

        pt = {$urandom, $urandom, $urandom, $urandom};
        exp_q.push_back(ref_enc(pt, ks128, 10));
        iv_a = 1'b1; or_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("queue_drained_postrst", exp_q.size(), 0);
        or_a = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
